// File: rtl/ext_irq_requester.sv
// ext_irq_requester
// Collects device interrupt lines and presents them one at a time to the core's
// external-interrupt input. Each request is held until the core acks it or a
// timeout aborts it.
//
// Ports
//   iCLOCK        sole clock, rising edge
//   iRESET_SYNC   synchronous active-high reset
//   iIRQ          device interrupt lines, rising-edge sensitive
//   iEN_WE        write strobe for the enable register
//   iEN_DATA      new enable mask (1 = source may be requested)
//   iERR_CLR      clears the sticky timeout flag
//   oEXT_ACTIVE   request valid to the core
//   oEXT_NUM      source index of the current request
//   iEXT_ACK      one-cycle ack pulse from the core
//   oPENDING      captured-edge pending bits
//   oENABLE       current enable register
//   oERR_TIMEOUT  sticky: a request was aborted by timeout
module ext_irq_requester #(
  parameter int unsigned P_SOURCES = 16,
  parameter int unsigned P_TIMEOUT = 1024
) (
  input  logic                 iCLOCK,
  input  logic                 iRESET_SYNC,
  input  logic [P_SOURCES-1:0] iIRQ,
  input  logic                 iEN_WE,
  input  logic [P_SOURCES-1:0] iEN_DATA,
  input  logic                 iERR_CLR,
  output logic                 oEXT_ACTIVE,
  output logic [5:0]           oEXT_NUM,
  input  logic                 iEXT_ACK,
  output logic [P_SOURCES-1:0] oPENDING,
  output logic [P_SOURCES-1:0] oENABLE,
  output logic                 oERR_TIMEOUT
);

  localparam int unsigned CntW = (P_TIMEOUT > 0) ? $clog2(P_TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(P_TIMEOUT - 1);
  localparam logic [5:0] LastInit = 6'(P_SOURCES - 1);

  typedef enum logic [1:0] {StIdle, StReq, StGap} state_e;

  state_e                state_q, state_d;
  logic [P_SOURCES-1:0]  pending_q, pending_d;
  logic [P_SOURCES-1:0]  irq_prev_q;
  logic [P_SOURCES-1:0]  enable_q, enable_d;
  logic                  err_q, err_d;
  logic                  active_q, active_d;
  logic [5:0]            num_q, num_d;
  logic [5:0]            grant_q, grant_d;
  logic [5:0]            last_q, last_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  logic [63:0]           elig_ext;
  logic                  any_elig;
  logic [5:0]            winner;
  logic [5:0]            idx;
  logic [P_SOURCES-1:0]  clr;
  logic                  timeout_hit;

  // Zero-extended so the 6-bit rotating index can address it directly.
  assign elig_ext = 64'(pending_q & enable_q);

  // Round-robin: scan starting one past the last acked/aborted grant.
  always_comb begin
    any_elig = 1'b0;
    winner   = '0;
    idx      = '0;
    for (int unsigned i = 0; i < P_SOURCES; i++) begin
      idx = 6'((32'(last_q) + 32'd1 + i) % P_SOURCES);
      if (!any_elig && elig_ext[idx]) begin
        any_elig = 1'b1;
        winner   = idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    num_d       = num_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    timeout_hit = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (any_elig) begin
          grant_d = winner;
          num_d   = winner;
          cnt_d   = '0;
          state_d = StReq;
        end
      end
      StReq: begin
        if (iEXT_ACK) begin
          last_d  = grant_q;
          state_d = StGap;
        end else if (P_TIMEOUT != 0 && cnt_q == CntLast) begin
          // Abort keeps the pending bit but still advances the pointer so a
          // stuck source cannot starve the others.
          timeout_hit = 1'b1;
          last_d      = grant_q;
          state_d     = StGap;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // A fresh edge on the granted source in the ack cycle re-sets pending.
  always_comb begin
    clr = '0;
    for (int unsigned k = 0; k < P_SOURCES; k++) begin
      clr[k] = (state_q == StReq) && iEXT_ACK && (6'(k) == grant_q);
    end
    pending_d = (pending_q & ~clr) | (iIRQ & ~irq_prev_q);
  end

  always_comb begin
    enable_d = iEN_WE ? iEN_DATA : enable_q;
    err_d    = timeout_hit ? 1'b1 : (iERR_CLR ? 1'b0 : err_q);
    active_d = (state_d == StReq);
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      state_q    <= StIdle;
      pending_q  <= '0;
      irq_prev_q <= '0;
      enable_q   <= '1;
      err_q      <= 1'b0;
      active_q   <= 1'b0;
      num_q      <= '0;
      grant_q    <= '0;
      last_q     <= LastInit;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      irq_prev_q <= iIRQ;
      enable_q   <= enable_d;
      err_q      <= err_d;
      active_q   <= active_d;
      num_q      <= num_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
    end
  end

  assign oEXT_ACTIVE  = active_q;
  assign oEXT_NUM     = num_q;
  assign oPENDING     = pending_q;
  assign oENABLE      = enable_q;
  assign oERR_TIMEOUT = err_q;

endmodule

// File: tb/tb_ext_irq_requester.sv
module tb_ext_irq_requester;

  localparam int unsigned NS = 16;
  localparam int unsigned TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [NS-1:0] irq;
  logic          en_we;
  logic [NS-1:0] en_data;
  logic          err_clr;
  logic          ack;
  logic          ext_active;
  logic [5:0]    ext_num;
  logic [NS-1:0] pending;
  logic [NS-1:0] enable;
  logic          err;

  always #5 clk = ~clk;

  ext_irq_requester #(
    .P_SOURCES(NS),
    .P_TIMEOUT(TO)
  ) dut (
    .iCLOCK      (clk),
    .iRESET_SYNC (rst),
    .iIRQ        (irq),
    .iEN_WE      (en_we),
    .iEN_DATA    (en_data),
    .iERR_CLR    (err_clr),
    .oEXT_ACTIVE (ext_active),
    .oEXT_NUM    (ext_num),
    .iEXT_ACK    (ack),
    .oPENDING    (pending),
    .oENABLE     (enable),
    .oERR_TIMEOUT(err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: request bookkeeping kept as plain flags/counters.
  int            exp_q[$];
  logic [NS-1:0] m_pend = '0;
  logic [NS-1:0] m_en   = '1;
  logic [NS-1:0] m_prev = '0;
  bit            m_busy = 0;   // a request is being presented
  int            m_gap  = 0;   // forced low cycles still to elapse
  int            m_wait = 0;   // cycles the current request has waited
  int            m_grant = 0;
  int            m_last = NS - 1;
  int            m_num  = 0;
  bit            m_err  = 0;

  always @(posedge clk) begin : model
    bit timed_out;
    bit found;
    int clr_src;
    int k;
    timed_out = 0;
    found     = 0;
    clr_src   = -1;
    if (rst) begin
      m_pend = '0; m_en = '1; m_prev = '0;
      m_busy = 0; m_gap = 0; m_wait = 0; m_grant = 0;
      m_last = NS - 1; m_num = 0; m_err = 0;
      exp_q.delete();
    end else begin
      if (m_busy) begin
        if (ack) begin
          clr_src = m_grant; m_last = m_grant; m_busy = 0; m_gap = 1;
        end else if (m_wait == TO - 1) begin
          timed_out = 1; m_last = m_grant; m_busy = 0; m_gap = 1;
        end else begin
          m_wait++;
        end
      end else if (m_gap > 0) begin
        m_gap--;
      end else begin
        for (int d = 1; d <= NS; d++) begin
          k = (m_last + d) % NS;
          if (!found && m_pend[k] && m_en[k]) begin
            found = 1; m_busy = 1; m_grant = k; m_num = k; m_wait = 0;
            exp_q.push_back(k);
          end
        end
      end
      for (int j = 0; j < NS; j++) begin
        if (j == clr_src) m_pend[j] = 1'b0;
        if (irq[j] && !m_prev[j]) m_pend[j] = 1'b1;
      end
      m_prev = irq;
      if (en_we) m_en = en_data;
      if (timed_out) m_err = 1;
      else if (err_clr) m_err = 0;
    end
  end

  // Monitor: pops an expected grant whenever the DUT raises a new request.
  logic prev_active = 1'b0;
  always @(negedge clk) begin
    if (!prev_active && ext_active) begin
      if (exp_q.size() == 0) chk("unexpected_request", {58'd0, ext_num}, 64'hFFFF);
      else chk("grant_num", {58'd0, ext_num}, 64'(exp_q.pop_front()));
    end
    chk("active",  {63'd0, ext_active}, {63'd0, m_busy});
    chk("num",     {58'd0, ext_num}, 64'(m_num));
    chk("pending", 64'(pending), 64'(m_pend));
    chk("enable",  64'(enable), 64'(m_en));
    chk("err",     {63'd0, err}, {63'd0, m_err});
    prev_active = ext_active;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_active();
    for (int i = 0; i < 50; i++) begin
      if (ext_active) break;
      step();
    end
    chk("wait_active", {63'd0, ext_active}, 64'd1);
  endtask

  task automatic pulse_irq(input logic [NS-1:0] m);
    irq = m; step(); irq = '0;
  endtask

  task automatic do_ack();
    ack = 1'b1; step(); ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; irq = '0; en_we = 1'b0; en_data = '0; err_clr = 1'b0; ack = 1'b0;
    steps(3);
    rst = 1'b0;
    step();

    // Single source with a late ack.
    pulse_irq(16'h0008); wait_active(); steps(5); do_ack(); steps(3);

    // Simultaneous edges, then a re-edge that must honour rotation.
    pulse_irq(16'h0026);
    for (int i = 0; i < 3; i++) begin wait_active(); step(); do_ack(); end
    steps(2);
    pulse_irq(16'h0022);
    for (int i = 0; i < 2; i++) begin wait_active(); step(); do_ack(); end
    steps(3);

    // Masking: only source 7 enabled, then release source 2.
    en_we = 1'b1; en_data = 16'h0080; step(); en_we = 1'b0;
    pulse_irq(16'h0084); wait_active(); do_ack(); steps(4);
    en_we = 1'b1; en_data = 16'h0084; step(); en_we = 1'b0;
    wait_active(); do_ack(); steps(2);
    en_we = 1'b1; en_data = '1; step(); en_we = 1'b0;

    // Ack collides with a fresh edge on the granted source.
    pulse_irq(16'h0010); wait_active(); step();
    ack = 1'b1; irq = 16'h0010; step(); ack = 1'b0; irq = '0;
    wait_active(); do_ack(); steps(3);

    // Timeouts: never ack two sources, then clear the flag.
    pulse_irq(16'h0600); steps(30);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    for (int i = 0; i < 2; i++) begin wait_active(); do_ack(); end
    steps(3);

    // Reset while a request is presented.
    pulse_irq(16'h0040); wait_active(); steps(2);
    pulse_irq(16'h1000);
    rst = 1'b1; step(); rst = 1'b0; steps(3);

    // Randomized traffic, including acks outside requests and no-ack windows.
    for (int c = 0; c < 3000; c++) begin
      irq     = irq ^ NS'($urandom & $urandom & $urandom);
      ack     = ((c / 400) % 3 == 2) ? 1'b0 : ($urandom_range(0, 2) == 0);
      en_we   = ($urandom_range(0, 15) == 0);
      en_data = NS'($urandom | $urandom);
      err_clr = ($urandom_range(0, 19) == 0);
      rst     = ($urandom_range(0, 499) == 0);
      step();
    end
    irq = '0; en_we = 1'b0; err_clr = 1'b0; rst = 1'b0; ack = 1'b1;
    steps(60);
    ack = 1'b0;
    steps(2);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
